// File: rtl/imm_gen_pkg.sv
// Shared definitions for the immediate-generation decode stage.
package imm_gen_pkg;

    localparam int unsigned ILEN  = 32;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned FMT_W = 3;

    // Immediate format codes presented on the stage output
    typedef enum logic [FMT_W-1:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    // Major opcodes (instr[6:0])
    localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [OPC_W-1:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP        = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LUI       = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_OP_32     = 7'b0111011;
    localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM    = 7'b1110011;

    // Classification produced by the decoder before immediate assembly
    typedef struct packed {
        fmt_e fmt;
        logic illegal;
    } dec_info_t;

    // Only RV32 and RV64 datapaths are supported
    function automatic logic xlen_legal(input int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Pure combinational RISC-V immediate decoder: instruction -> immediate, format, illegal.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter bit          ZIMM_EN = 1'b1
) (
    input  logic [ILEN-1:0] instr_i,
    output logic [XLEN-1:0] imm_c_o,
    output fmt_e            fmt_c_o,
    output logic            illegal_c_o
);

    // RV64-only opcodes are decoded only on a legal 64-bit datapath
    localparam bit RV64 = xlen_legal(XLEN) && (XLEN == 64);

    dec_info_t   info;
    logic [31:0] imm32;
    logic        sgn;

    // Opcode classification; anything unrecognised is flagged illegal with format NONE
    always_comb begin
        info = '{fmt: FMT_NONE, illegal: 1'b0};
        if (instr_i[1:0] != 2'b11) begin
            info.illegal = 1'b1;
        end else begin
            case (instr_i[OPC_W-1:0])
                OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM: info.fmt = FMT_I;
                OPC_OP_IMM_32: begin
                    if (RV64) info.fmt = FMT_I;
                    else      info.illegal = 1'b1;
                end
                OPC_STORE:           info.fmt = FMT_S;
                OPC_BRANCH:          info.fmt = FMT_B;
                OPC_AUIPC, OPC_LUI:  info.fmt = FMT_U;
                OPC_JAL:             info.fmt = FMT_J;
                OPC_OP:              info.fmt = FMT_NONE;
                OPC_OP_32: begin
                    if (!RV64) info.illegal = 1'b1;
                end
                OPC_SYSTEM: info.fmt = (ZIMM_EN && instr_i[14]) ? FMT_Z : FMT_I;
                default:    info.illegal = 1'b1;
            endcase
        end
    end

    // 32-bit immediate assembly; widened below by sign extension of bit 31
    always_comb begin
        sgn   = instr_i[31];
        imm32 = '0;
        case (info.fmt)
            FMT_I: imm32 = {{20{sgn}}, instr_i[31:20]};
            FMT_S: imm32 = {{20{sgn}}, instr_i[31:25], instr_i[11:7]};
            FMT_B: imm32 = {{19{sgn}}, sgn, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_U: imm32 = {instr_i[31:12], 12'b0};
            FMT_J: imm32 = {{11{sgn}}, sgn, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            // zimm has bit 31 clear, so the sign extension below zero-extends it
            FMT_Z: imm32 = {27'b0, instr_i[19:15]};
            default: imm32 = '0;
        endcase
    end

    assign imm_c_o     = XLEN'($signed(imm32));
    assign fmt_c_o     = info.fmt;
    assign illegal_c_o = info.illegal;

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decoder feeding a 2-entry FIFO with valid/ready on both sides.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter bit          ZIMM_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ILEN-1:0]  in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ILEN-1:0]  out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [FMT_W-1:0] out_fmt,
    output logic             out_illegal
);

    localparam int unsigned CNT_W = 2;

    // One buffered decode result
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } entry_t;

    logic [XLEN-1:0]  dec_imm;
    fmt_e             dec_fmt;
    logic             dec_ill;
    entry_t           new_e;

    // head_q drives the outputs directly; tail_q only holds the second entry under backpressure
    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_ready_q, out_valid_q;
    logic             push, pop;

    imm_decode #(
        .XLEN    (XLEN),
        .ZIMM_EN (ZIMM_EN)
    ) u_imm_decode (
        .instr_i     (in_instr),
        .imm_c_o     (dec_imm),
        .fmt_c_o     (dec_fmt),
        .illegal_c_o (dec_ill)
    );

    // Candidate entry built from the current input and its decode
    always_comb begin
        new_e = '{instr: in_instr, pc: in_pc, imm: dec_imm, fmt: dec_fmt, illegal: dec_ill};
    end

    // Handshakes use registered ready/valid only, so there is no path from out_ready to in_ready
    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    // FIFO next-state: flush wins over push/pop; a push with a pop at one entry replaces the head
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case (count_q)
                CNT_W'(0): begin
                    if (push) begin
                        head_d  = new_e;
                        count_d = CNT_W'(1);
                    end
                end
                CNT_W'(1): begin
                    if (push && pop) begin
                        head_d = new_e;
                    end else if (push) begin
                        tail_d  = new_e;
                        count_d = CNT_W'(2);
                    end else if (pop) begin
                        count_d = CNT_W'(0);
                    end
                end
                CNT_W'(2): begin
                    if (pop) begin
                        head_d  = tail_q;
                        count_d = CNT_W'(1);
                    end
                end
                default: count_d = '0;
            endcase
        end
    end

    // State and registered handshake flags; reset overrides flush
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_ready_q  <= (count_d != CNT_W'(2));
            out_valid_q <= (count_d != CNT_W'(0));
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_instr   = head_q.instr;
    assign out_pc      = head_q.pc;
    assign out_imm     = head_q.imm;
    assign out_fmt     = head_q.fmt;
    assign out_illegal = head_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench: an RV32 and an RV64 instance share one stimulus stream.
module tb_imm_gen_stage;

    localparam int unsigned CYCLES = 3000;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_instr32, out_pc32, out_imm32;
    logic [2:0]  out_fmt32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [31:0] out_instr64;
    logic [63:0] out_pc64, out_imm64;
    logic [2:0]  out_fmt64;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   model_on = 1'b0;
    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .ZIMM_EN(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_instr(out_instr32), .out_pc(out_pc32), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_illegal(out_illegal32)
    );

    imm_gen_stage #(.XLEN(64), .ZIMM_EN(1'b1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_instr(out_instr64), .out_pc(out_pc64), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_illegal(out_illegal64)
    );

    // Reference decode from the ISA immediate rules, using signed arithmetic for extension
    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [63:0] pc, input bit x64);
        exp_t       e;
        logic [6:0] op;
        e.instr = ins; e.pc = pc; e.imm = '0; e.fmt = 3'd0; e.ill = 1'b0;
        op = ins[6:0];
        if (ins[1:0] != 2'b11) begin
            e.ill = 1'b1;
        end else if (op == 7'b0110011 || (x64 && op == 7'b0111011)) begin
            e.fmt = 3'd0;
        end else if (op == 7'b0000011 || op == 7'b0010011 || op == 7'b1100111 || op == 7'b0001111
                     || (x64 && op == 7'b0011011) || (op == 7'b1110011 && !ins[14])) begin
            e.fmt = 3'd1; e.imm = 64'($signed(ins[31:20]));
        end else if (op == 7'b1110011) begin
            e.fmt = 3'd6; e.imm = 64'(ins[19:15]);
        end else if (op == 7'b0100011) begin
            e.fmt = 3'd2; e.imm = 64'($signed({ins[31:25], ins[11:7]}));
        end else if (op == 7'b1100011) begin
            e.fmt = 3'd3; e.imm = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        end else if (op == 7'b0010111 || op == 7'b0110111) begin
            e.fmt = 3'd4; e.imm = 64'($signed({ins[31:12], 12'b0}));
        end else if (op == 7'b1101111) begin
            e.fmt = 3'd5; e.imm = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input int sz, input exp_t h,
                             input logic rdy, input logic vld, input logic [31:0] ins,
                             input logic [63:0] pc, input logic [63:0] imm,
                             input logic [2:0] fmt, input logic ill, input logic [63:0] mask);
        chk({tag, " in_ready"}, 64'(rdy), 64'(sz != 2));
        chk({tag, " out_valid"}, 64'(vld), 64'(sz != 0));
        if (sz != 0 && vld === 1'b1) begin
            chk({tag, " out_instr"}, 64'(ins), 64'(h.instr));
            chk({tag, " out_pc"}, pc, h.pc & mask);
            chk({tag, " out_imm"}, imm, h.imm & mask);
            chk({tag, " out_fmt"}, 64'(fmt), 64'(h.fmt));
            chk({tag, " out_illegal"}, 64'(ill), 64'(ill_of(h)));
        end
    endtask

    function automatic logic ill_of(input exp_t h);
        return h.ill;
    endfunction

    // Monitor: compare DUT outputs with the queue heads, then advance the model for the coming edge
    always @(negedge clk) begin
        exp_t h32, h64;
        bit   full;
        h32 = '{default: '0};
        h64 = '{default: '0};
        if (q32.size() != 0) h32 = q32[0];
        if (q64.size() != 0) h64 = q64[0];
        if (model_on) begin
            check_dut("x32", q32.size(), h32, in_ready32, out_valid32, out_instr32,
                      64'(out_pc32), 64'(out_imm32), out_fmt32, out_illegal32, 64'h0000_0000_FFFF_FFFF);
            check_dut("x64", q64.size(), h64, in_ready64, out_valid64, out_instr64,
                      out_pc64, out_imm64, out_fmt64, out_illegal64, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        if (rst_n !== 1'b1) begin
            q32.delete(); q64.delete();
            model_on = 1'b1;
        end else if (model_on) begin
            if (flush) begin
                q32.delete(); q64.delete();
            end else begin
                full = (q32.size() == 2);
                if (out_ready && q32.size() != 0) void'(q32.pop_front());
                if (out_ready && q64.size() != 0) void'(q64.pop_front());
                if (in_valid && !full) begin
                    q32.push_back(ref_dec(in_instr, in_pc, 1'b0));
                    q64.push_back(ref_dec(in_instr, in_pc, 1'b1));
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [31:0] ins, input bit ordy, input bit fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = {$urandom, $urandom} & ~64'h3;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Hold an instruction on the input until the stage accepts it
    task automatic push(input logic [31:0] ins, input bit ordy);
        int t = 0;
        do begin
            drive(1'b1, ins, ordy, 1'b0);
            t++;
        end while (!in_ready32 && t < 50);
        if (!in_ready32) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: in_ready stuck at %0b, required 1", in_ready32);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [16] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111,
                                  7'b0011011, 7'b0100011, 7'b1100011, 7'b0010111,
                                  7'b0110111, 7'b1101111, 7'b0110011, 7'b0111011,
                                  7'b1110011, 7'b1110011, 7'b1010011, 7'b0000000};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 15)];
        return w;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state of both instances
        @(negedge clk);
        chk("rst out_valid32", 64'(out_valid32), 64'd0);
        chk("rst in_ready32", 64'(in_ready32), 64'd1);
        chk("rst out_instr32", 64'(out_instr32), 64'd0);
        chk("rst out_pc32", 64'(out_pc32), 64'd0);
        chk("rst out_imm32", 64'(out_imm32), 64'd0);
        chk("rst out_fmt32", 64'(out_fmt32), 64'd0);
        chk("rst out_illegal32", 64'(out_illegal32), 64'd0);
        chk("rst out_valid64", 64'(out_valid64), 64'd0);
        chk("rst out_imm64", out_imm64, 64'd0);
        chk("rst out_pc64", out_pc64, 64'd0);

        // Known encodings: addi -1, beq -4, lui, lui 0x80000, csrrwi zimm 31, two illegal words
        push(32'hFFF0_0093, 1'b1);
        push(32'hFE00_0EE3, 1'b1);
        push(32'h1234_50B7, 1'b1);
        push(32'h8000_00B7, 1'b1);
        push(32'h300F_D073, 1'b1);
        push(32'h0000_0000, 1'b1);
        push(32'h0000_007F, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: A and B fill the buffer, C waits until the stall releases
        push(32'h0010_0113, 1'b0);
        push(32'h0020_01A3, 1'b0);
        repeat (3) drive(1'b1, 32'h0030_0213, 1'b0, 1'b0);
        push(32'h0030_0213, 1'b1);
        repeat (4) drive(1'b0, '0, 1'b1, 1'b0);

        // Flush with a simultaneous push at full occupancy
        push(32'h0040_0293, 1'b0);
        push(32'h0050_0313, 1'b0);
        drive(1'b1, 32'h0060_0393, 1'b0, 1'b1);
        repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

        // Reset at full occupancy with a push offered
        push(32'h0070_0413, 1'b0);
        push(32'h0080_0493, 1'b0);
        drive(1'b1, 32'h0090_0513, 1'b0, 1'b0);
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

        // Randomised traffic with backpressure, occasional flush and reset
        for (int i = 0; i < int'(CYCLES); i++) begin
            drive(1'($urandom_range(0, 3) != 0), rand_instr(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
            rst_n = 1'($urandom_range(0, 299) != 0);
        end
        rst_n = 1'b1;
        repeat (5) drive(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
